// File: rtl/store_buffer_if.sv
// Bus between the MEM stage / data memory and the store buffer.
// The master side drives store/load requests; the slave side is the buffer itself.
interface store_buffer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  st_valid;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [DATA_W-1:0]     st_data;
    logic [2:0]            st_funct3;
    logic                  st_ready;

    logic                  ld_valid;
    logic [DM_ADDRESS-1:0] ld_addr;
    logic                  ld_hit;
    logic                  ld_conflict;
    logic [DATA_W-1:0]     ld_fwd_data;

    logic                  mem_busy;
    logic                  dm_write;
    logic [DM_ADDRESS-1:0] dm_addr;
    logic [DATA_W-1:0]     dm_wd;
    logic [2:0]            dm_funct3;

    logic                  flush_req;
    logic                  empty;
    logic [CW-1:0]         count;

    modport master (
        output st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, mem_busy, flush_req,
        input  st_ready, ld_hit, ld_conflict, ld_fwd_data, dm_write, dm_addr, dm_wd, dm_funct3,
               empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, ld_valid, ld_addr, mem_busy, flush_req,
        output st_ready, ld_hit, ld_conflict, ld_fwd_data, dm_write, dm_addr, dm_wd, dm_funct3,
               empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data memory: drains one store per
// free memory cycle and forwards buffered full-word stores to matching loads.
module store_buffer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DM_ADDRESS-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [2:0]            f3_q   [DEPTH];
    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;

    logic st_ready_w, enq, deq, is_empty;
    logic unused_ld_bits;

    assign is_empty   = (count_q == '0);
    assign st_ready_w = (count_q < CW'(DEPTH)) && !sb.flush_req;
    assign enq        = sb.st_valid && st_ready_w;
    assign deq        = !is_empty && !sb.mem_busy;

    assign sb.st_ready = st_ready_w;
    assign sb.dm_write = deq;
    assign sb.empty    = is_empty;
    assign sb.count    = count_q;
    assign unused_ld_bits = ^sb.ld_addr[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                f3_q[i]   <= '0;
            end
        end else begin
            if (enq) begin
                addr_q[tail_q] <= sb.st_addr;
                data_q[tail_q] <= sb.st_data;
                f3_q[tail_q]   <= sb.st_funct3;
                tail_q         <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        sb.dm_addr   = '0;
        sb.dm_wd     = '0;
        sb.dm_funct3 = '0;
        if (!is_empty) begin
            sb.dm_addr   = addr_q[head_q];
            sb.dm_wd     = data_q[head_q];
            sb.dm_funct3 = f3_q[head_q];
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    logic          match_found;
    logic [PW-1:0] match_idx;
    logic [PW-1:0] idx;

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) &&
                (addr_q[idx][DM_ADDRESS-1:2] == sb.ld_addr[DM_ADDRESS-1:2])) begin
                match_found = 1'b1;
                match_idx   = idx;
            end
        end
    end

    always_comb begin
        sb.ld_hit      = 1'b0;
        sb.ld_conflict = 1'b0;
        sb.ld_fwd_data = '0;
        if (sb.ld_valid && match_found) begin
            // Only byte/halfword stores block; any other size code forwards as a word.
            if (f3_q[match_idx] == 3'b000 || f3_q[match_idx] == 3'b001) begin
                sb.ld_conflict = 1'b1;
            end else begin
                sb.ld_hit      = 1'b1;
                sb.ld_fwd_data = data_q[match_idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed test of store_buffer: drain latency, fill/stall/wrap, forwarding,
// simultaneous enqueue/dequeue, flush and mid-operation reset.
module tb_store_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    store_buffer_if #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) sbi ();

    store_buffer #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sbi.st_valid  = 1'b0;
        sbi.st_addr   = '0;
        sbi.st_data   = '0;
        sbi.st_funct3 = 3'b010;
        sbi.ld_valid  = 1'b0;
        sbi.ld_addr   = '0;
        sbi.mem_busy  = 1'b0;
        sbi.flush_req = 1'b0;
    endtask

    task automatic put_store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f3);
        sbi.st_valid  = 1'b1;
        sbi.st_addr   = a;
        sbi.st_data   = d;
        sbi.st_funct3 = f3;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", sbi.empty); end
        checks++; if (sbi.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", sbi.count); end
        checks++; if (sbi.st_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", sbi.st_ready); end
        checks++; if ({sbi.dm_write, sbi.ld_hit, sbi.ld_conflict} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {sbi.dm_write, sbi.ld_hit, sbi.ld_conflict}); end
        checks++; if ({sbi.dm_addr, sbi.dm_wd, sbi.dm_funct3, sbi.ld_fwd_data} !== '0) begin errors++; $display("FAIL rst_data got %h/%h/%b/%h exp 0", sbi.dm_addr, sbi.dm_wd, sbi.dm_funct3, sbi.ld_fwd_data); end
        sbi.flush_req = 1'b1;
        #1;
        checks++; if (sbi.st_ready !== 1'b0) begin errors++; $display("FAIL rst_flush_ready got %b exp 0", sbi.st_ready); end
        sbi.flush_req = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_sw();
        put_store(9'h010, 32'hDEADBEEF, 3'b010);
        #1;
        checks++; if (sbi.st_ready !== 1'b1) begin errors++; $display("FAIL sw_ready got %b exp 1", sbi.st_ready); end
        checks++; if (sbi.dm_write !== 1'b0) begin errors++; $display("FAIL sw_nodrain_same_cycle got %b exp 0", sbi.dm_write); end
        step();
        idle_inputs();
        #1;
        checks++; if (sbi.dm_write !== 1'b1) begin errors++; $display("FAIL sw_dm_write got %b exp 1", sbi.dm_write); end
        checks++; if (sbi.dm_addr !== 9'h010) begin errors++; $display("FAIL sw_dm_addr got %h exp 010", sbi.dm_addr); end
        checks++; if (sbi.dm_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dm_wd got %h exp deadbeef", sbi.dm_wd); end
        checks++; if (sbi.dm_funct3 !== 3'b010) begin errors++; $display("FAIL sw_dm_funct3 got %b exp 010", sbi.dm_funct3); end
        step();
        checks++; if (sbi.empty !== 1'b1 || sbi.dm_write !== 1'b0) begin errors++; $display("FAIL sw_empty_after got empty=%b wr=%b exp 1/0", sbi.empty, sbi.dm_write); end
    endtask

    task automatic test_fill_stall_wrap();
        sbi.mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put_store(9'h100 + 9'(4 * i), 32'hA0 + 32'(i), 3'b010);
            #1;
            checks++; if (sbi.st_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready[%0d] got %b exp %b", i, sbi.st_ready, (i < 4)); end
            checks++; if (sbi.dm_write !== 1'b0) begin errors++; $display("FAIL fill_busy_write[%0d] got %b exp 0", i, sbi.dm_write); end
            step();
        end
        sbi.st_valid = 1'b0;
        #1;
        checks++; if (sbi.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", sbi.count); end
        sbi.mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sbi.dm_write !== 1'b1 || sbi.dm_addr !== 9'h100 + 9'(4 * i) || sbi.dm_wd !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL drain[%0d] got wr=%b addr=%h wd=%h exp 1/%h/%h", i, sbi.dm_write, sbi.dm_addr, sbi.dm_wd, 9'h100 + 9'(4 * i), 32'hA0 + 32'(i));
            end
            step();
        end
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", sbi.empty); end
        sbi.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put_store(9'h180 + 9'(4 * i), 32'hB0 + 32'(i), 3'b010);
            step();
        end
        sbi.st_valid = 1'b0;
        #1;
        checks++; if (sbi.count !== 3'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", sbi.count); end
        sbi.mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sbi.dm_addr !== 9'h180 + 9'(4 * i) || sbi.dm_wd !== 32'hB0 + 32'(i)) begin
                errors++; $display("FAIL wrap_drain[%0d] got addr=%h wd=%h exp %h/%h", i, sbi.dm_addr, sbi.dm_wd, 9'h180 + 9'(4 * i), 32'hB0 + 32'(i));
            end
            step();
        end
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", sbi.empty); end
    endtask

    task automatic test_forwarding();
        sbi.mem_busy = 1'b1;
        put_store(9'h020, 32'h11111111, 3'b010); step();
        put_store(9'h020, 32'h22222222, 3'b010); step();
        sbi.st_valid = 1'b0;
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = 9'h022;
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b10 || sbi.ld_fwd_data !== 32'h22222222) begin
            errors++; $display("FAIL fwd_youngest_sw got hit=%b conf=%b data=%h exp 1/0/22222222", sbi.ld_hit, sbi.ld_conflict, sbi.ld_fwd_data);
        end
        put_store(9'h021, 32'h000000FF, 3'b000);
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b10 || sbi.ld_fwd_data !== 32'h22222222) begin
            errors++; $display("FAIL fwd_excl_enqueue got hit=%b conf=%b data=%h exp 1/0/22222222", sbi.ld_hit, sbi.ld_conflict, sbi.ld_fwd_data);
        end
        step();
        sbi.st_valid = 1'b0;
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b01 || sbi.ld_fwd_data !== 32'h0) begin
            errors++; $display("FAIL fwd_sb_conflict got hit=%b conf=%b data=%h exp 0/1/0", sbi.ld_hit, sbi.ld_conflict, sbi.ld_fwd_data);
        end
        sbi.ld_addr = 9'h030;
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b00 || sbi.ld_fwd_data !== 32'h0) begin
            errors++; $display("FAIL fwd_nomatch got hit=%b conf=%b data=%h exp 0/0/0", sbi.ld_hit, sbi.ld_conflict, sbi.ld_fwd_data);
        end
        sbi.ld_addr  = 9'h022;
        sbi.ld_valid = 1'b0;
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b00) begin errors++; $display("FAIL fwd_ld_invalid got %b exp 00", {sbi.ld_hit, sbi.ld_conflict}); end
        put_store(9'h024, 32'h33333333, 3'b111); step();
        sbi.st_valid = 1'b0;
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = 9'h027;
        #1;
        checks++; if ({sbi.ld_hit, sbi.ld_conflict} !== 2'b10 || sbi.ld_fwd_data !== 32'h33333333) begin
            errors++; $display("FAIL fwd_unknown_f3 got hit=%b conf=%b data=%h exp 1/0/33333333", sbi.ld_hit, sbi.ld_conflict, sbi.ld_fwd_data);
        end
        sbi.mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] f3_exp;
            f3_exp = (i < 2) ? 3'b010 : ((i == 2) ? 3'b000 : 3'b111);
            #1;
            checks++; if (sbi.dm_funct3 !== f3_exp) begin errors++; $display("FAIL fwd_drain_f3[%0d] got %b exp %b", i, sbi.dm_funct3, f3_exp); end
            if (i == 3) begin
                checks++; if (sbi.dm_write !== 1'b1 || sbi.ld_hit !== 1'b1) begin errors++; $display("FAIL fwd_head_draining got wr=%b hit=%b exp 1/1", sbi.dm_write, sbi.ld_hit); end
            end
            step();
        end
        sbi.ld_valid = 1'b0;
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL fwd_empty got %b exp 1", sbi.empty); end
    endtask

    task automatic test_back_to_back();
        sbi.mem_busy = 1'b1;
        put_store(9'h040, 32'h1, 3'b010); step();
        put_store(9'h044, 32'h2, 3'b010); step();
        sbi.mem_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            put_store(9'h048 + 9'(4 * i), 32'h3 + 32'(i), 3'b010);
            #1;
            checks++; if (sbi.st_ready !== 1'b1 || sbi.dm_write !== 1'b1 || sbi.dm_addr !== 9'h040 + 9'(4 * i)) begin
                errors++; $display("FAIL simul[%0d] got rdy=%b wr=%b addr=%h exp 1/1/%h", i, sbi.st_ready, sbi.dm_write, sbi.dm_addr, 9'h040 + 9'(4 * i));
            end
            step();
            checks++; if (sbi.count !== 3'd2) begin errors++; $display("FAIL simul_count[%0d] got %0d exp 2", i, sbi.count); end
        end
        sbi.st_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (sbi.dm_addr !== 9'h048 + 9'(4 * i) || sbi.dm_wd !== 32'h3 + 32'(i)) begin
                errors++; $display("FAIL simul_order[%0d] got addr=%h wd=%h exp %h/%h", i, sbi.dm_addr, sbi.dm_wd, 9'h048 + 9'(4 * i), 32'h3 + 32'(i));
            end
            step();
        end
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", sbi.empty); end
    endtask

    task automatic test_flush();
        sbi.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put_store(9'h050 + 9'(4 * i), 32'h50 + 32'(i), 3'b010);
            step();
        end
        put_store(9'h0F0, 32'hBAD0BAD0, 3'b010);
        sbi.flush_req = 1'b1;
        sbi.mem_busy  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (sbi.st_ready !== 1'b0 || sbi.dm_write !== 1'b1 || sbi.dm_addr !== 9'h050 + 9'(4 * i)) begin
                errors++; $display("FAIL flush[%0d] got rdy=%b wr=%b addr=%h exp 0/1/%h", i, sbi.st_ready, sbi.dm_write, sbi.dm_addr, 9'h050 + 9'(4 * i));
            end
            step();
        end
        checks++; if (sbi.empty !== 1'b1 || sbi.count !== 3'd0) begin errors++; $display("FAIL flush_empty got empty=%b count=%0d exp 1/0", sbi.empty, sbi.count); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        sbi.mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put_store(9'h060 + 9'(4 * i), 32'h60 + 32'(i), 3'b010);
            step();
        end
        sbi.st_valid = 1'b0;
        sbi.mem_busy = 1'b0;
        #1;
        checks++; if (sbi.count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count got %0d exp 3", sbi.count); end
        reset = 1'b1;
        #1;
        checks++; if (sbi.count !== 3'd0 || sbi.dm_write !== 1'b0 || sbi.empty !== 1'b1 || sbi.dm_addr !== 9'h0) begin
            errors++; $display("FAIL rmid_async got count=%0d wr=%b empty=%b addr=%h exp 0/0/1/000", sbi.count, sbi.dm_write, sbi.empty, sbi.dm_addr);
        end
        step();
        reset = 1'b0;
        put_store(9'h070, 32'hCAFEF00D, 3'b010);
        #1;
        checks++; if (sbi.dm_write !== 1'b0) begin errors++; $display("FAIL rmid_no_stale got wr=%b exp 0", sbi.dm_write); end
        step();
        sbi.st_valid = 1'b0;
        #1;
        checks++; if (sbi.dm_write !== 1'b1 || sbi.dm_addr !== 9'h070 || sbi.dm_wd !== 32'hCAFEF00D || sbi.count !== 3'd1) begin
            errors++; $display("FAIL rmid_new_sw got wr=%b addr=%h wd=%h count=%0d exp 1/070/cafef00d/1", sbi.dm_write, sbi.dm_addr, sbi.dm_wd, sbi.count);
        end
        step();
        checks++; if (sbi.empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", sbi.empty); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_sw();
        test_fill_stall_wrap();
        test_forwarding();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
